// File: rtl/spi_exe_unit_4_if.sv
// spi_exe_unit_4_if: SPI slave pins plus status outputs of the execution unit
interface spi_exe_unit_4_if #(parameter int BITS = 8);
   logic            i_cs;
   logic            i_mosi;
   logic            o_miso;
   logic            o_busy;
   logic            o_done;
   logic [1:0]      o_opcode;
   logic [BITS-1:0] o_reg;
   modport master (output i_cs, i_mosi, input o_miso, o_busy, o_done, o_opcode, o_reg);
   modport slave  (input i_cs, i_mosi, output o_miso, o_busy, o_done, o_opcode, o_reg);
endinterface

// File: rtl/spi_exe_unit_4.sv
// spi_exe_unit_4: SPI mode-0 slave executing echo, inverted echo, register write and register read
module spi_exe_unit_4 #(
   parameter int              BITS     = 8,
   parameter int              DELAY    = 5,
   parameter logic [BITS-1:0] REG_INIT = '0
) (
   input logic              i_sclk,
   input logic              i_rst,
   spi_exe_unit_4_if.slave  bus
);
   localparam int CW = $clog2(BITS + 2);
   typedef enum logic [1:0] {IDLE, OPC, DATA, DONE} state_t;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DELAY-1:0] dl_q, dl_d;
   logic [BITS-1:0] sh_q, sh_d, reg_q, reg_d;
   logic [1:0]      opc_q, opc_d;
   logic            op1_q, op1_d, ob_q, ob_d, last;
   // next-state and datapath: sh doubles as MISO source and write assembler
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dl_d    = dl_q;
      sh_d    = sh_q;
      op1_d   = op1_q;
      opc_d   = opc_q;
      reg_d   = reg_q;
      last    = state_q == DATA && cnt_q == CW'(BITS + 1);
      case (state_q)
         IDLE: begin
            state_d = OPC;
            cnt_d   = CW'(1);
            op1_d   = bus.i_mosi;
         end
         OPC: begin
            state_d = DATA;
            cnt_d   = CW'(2);
            opc_d   = {op1_q, bus.i_mosi};
            sh_d    = reg_q;
         end
         DATA: begin
            dl_d    = DELAY'({dl_q, bus.i_mosi});
            sh_d    = {sh_q[BITS-2:0], bus.i_mosi};
            cnt_d   = last ? cnt_q : cnt_q + CW'(1);
            state_d = last ? DONE : DATA;
            reg_d   = (last && opc_q == 2'b10) ? {sh_q[BITS-2:0], bus.i_mosi} : reg_q;
         end
         default: ;
      endcase
      ob_d = state_q == DATA && (opc_q[1] ? sh_q[BITS-1] :
             (int'(cnt_q) >= DELAY + 2) && (dl_q[DELAY-1] ^ opc_q[0]));
   end
   // frame state, cleared whenever chip select is high
   always_ff @(posedge i_sclk or posedge i_rst or posedge bus.i_cs) begin
      if (i_rst || bus.i_cs) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dl_q    <= '0;
         sh_q    <= '0;
         op1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dl_q    <= dl_d;
         sh_q    <= sh_d;
         op1_q   <= op1_d;
      end
   end
   // opcode and register survive chip-select deassertion
   always_ff @(posedge i_sclk or posedge i_rst) begin
      if (i_rst) begin
         opc_q <= 2'b00;
         reg_q <= REG_INIT;
      end else begin
         opc_q <= opc_d;
         reg_q <= reg_d;
      end
   end
   // MISO bit launched on the falling edge ahead of the sampling edge
   always_ff @(negedge i_sclk or posedge i_rst or posedge bus.i_cs) begin
      if (i_rst || bus.i_cs) ob_q <= 1'b0;
      else                   ob_q <= ob_d;
   end
   assign bus.o_miso   = ob_q & ~bus.i_cs;
   assign bus.o_busy   = ~bus.i_cs & (state_q == OPC || state_q == DATA);
   assign bus.o_done   = ~bus.i_cs & (state_q == DONE);
   assign bus.o_opcode = opc_q;
   assign bus.o_reg    = reg_q;
endmodule
